// File: rtl/l2_req_responder_if.sv
// L1-request / memory / response bus of the L2 request responder.
// master: the environment (L1 and memory side); slave: the responder itself.
interface l2_req_responder_if;
    logic        req_valid;
    logic [1:0]  cmd_in;
    logic [25:0] add_in;
    logic        req_ready;
    logic        mem_req;
    logic        mem_we;
    logic [25:0] mem_addr;
    logic        mem_ack;
    logic        resp_valid;
    logic [25:0] resp_addr;
    logic [1:0]  resp_cmd;
    logic        resp_err;

    modport master (
        output req_valid, cmd_in, add_in, mem_ack,
        input  req_ready, mem_req, mem_we, mem_addr,
               resp_valid, resp_addr, resp_cmd, resp_err
    );

    modport slave (
        input  req_valid, cmd_in, add_in, mem_ack,
        output req_ready, mem_req, mem_we, mem_addr,
               resp_valid, resp_addr, resp_cmd, resp_err
    );
endinterface

// File: rtl/l2_req_responder.sv
// L2 request responder: queues L1 READ/RFO requests in a small FIFO and
// issues them one at a time to memory, answering each with a one-cycle
// completion pulse (error flagged if memory never acknowledged).
module l2_req_responder #(
    parameter int DEPTH       = 4,   // power of 2, >= 2
    parameter int MEM_TIMEOUT = 64   // 1..255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    l2_req_responder_if.slave     bus,
    output logic [31:0]           read_cnt,
    output logic [31:0]           write_cnt,
    output logic [15:0]           timeout_cnt,
    output logic [15:0]           illegal_cnt
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [7:0]    TO_LAST  = 8'(MEM_TIMEOUT - 1);
    localparam logic [1:0]    CMD_RD   = 2'b01;
    localparam logic [1:0]    CMD_WR   = 2'b10;
    localparam logic [1:0]    CMD_ILL  = 2'b11;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    typedef struct packed {
        logic [1:0]  cmd;
        logic [25:0] addr;
    } entry_t;

    entry_t        fifo_q [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop;
    entry_t        head;

    state_t        state, state_d;
    logic [7:0]    timer;
    logic          err_q;
    logic          timeout;

    assign full          = (count == FULL_CNT);
    assign empty         = (count == '0);
    assign bus.req_ready = !full;
    assign push          = bus.req_valid && !full &&
                           (bus.cmd_in == CMD_RD || bus.cmd_in == CMD_WR);
    // the head is consumed on the edge that leaves RESP
    assign pop           = (state == RESP);
    assign head          = fifo_q[rd_ptr];

    // FIFO storage; contents need no reset, occupancy is tracked separately
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr] <= entry_t'{bus.cmd_in, bus.add_in};
    end

    // FIFO pointers and occupancy; push+pop together leaves count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // state register, REQ timer and the error flag latched on leaving REQ
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_d;
            if (state == IDLE)     timer <= '0;
            else if (state == REQ) timer <= timer + 1'b1;
            if (state == REQ)      err_q <= timeout;
        end
    end

    // next state and bus outputs; ack takes priority over the timeout
    always_comb begin
        state_d        = state;
        timeout        = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.resp_valid = 1'b0;
        bus.resp_addr  = '0;
        bus.resp_cmd   = '0;
        bus.resp_err   = 1'b0;
        case (state)
            IDLE: if (!empty) state_d = REQ;
            REQ: begin
                bus.mem_req  = 1'b1;
                bus.mem_we   = (head.cmd == CMD_WR);
                bus.mem_addr = head.addr;
                if (bus.mem_ack) begin
                    state_d = RESP;
                end else if (timer == TO_LAST) begin
                    state_d = RESP;
                    timeout = 1'b1;
                end
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_addr  = head.addr;
                bus.resp_cmd   = head.cmd;
                bus.resp_err   = err_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // statistics: wrapping accept counters, saturating error counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_cnt    <= '0;
            write_cnt   <= '0;
            timeout_cnt <= '0;
            illegal_cnt <= '0;
        end else begin
            if (push && bus.cmd_in == CMD_RD) read_cnt  <= read_cnt + 1'b1;
            if (push && bus.cmd_in == CMD_WR) write_cnt <= write_cnt + 1'b1;
            if (timeout && timeout_cnt != 16'hFFFF)
                timeout_cnt <= timeout_cnt + 1'b1;
            if (bus.req_valid && bus.cmd_in == CMD_ILL && illegal_cnt != 16'hFFFF)
                illegal_cnt <= illegal_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_l2_req_responder.sv
// Directed bench for l2_req_responder: expected completions are queued at
// issue time and a negedge monitor pops and compares each resp_valid pulse.
module tb_l2_req_responder;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] read_cnt, write_cnt;
    logic [15:0] timeout_cnt, illegal_cnt;

    l2_req_responder_if bus();

    l2_req_responder #(.DEPTH(4), .MEM_TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .read_cnt(read_cnt), .write_cnt(write_cnt),
        .timeout_cnt(timeout_cnt), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  cmd;
        logic [25:0] addr;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (bus.resp_valid === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL resp_unexpected: got addr %0h cmd %0h, expected no response",
                         bus.resp_addr, bus.resp_cmd);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.resp_addr !== e.addr || bus.resp_cmd !== e.cmd || bus.resp_err !== e.err) begin
                    miscompares++;
                    $display("FAIL resp: got addr %0h cmd %0h err %0b expected addr %0h cmd %0h err %0b",
                             bus.resp_addr, bus.resp_cmd, bus.resp_err, e.addr, e.cmd, e.err);
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk); #1;
    endtask

    // drive one request for one edge; expectations are hand-computed by caller
    task automatic send(input logic [1:0] cmd, input logic [25:0] a,
                        input logic exp_rdy, input logic exp_push, input logic exp_err);
        bus.req_valid = 1'b1;
        bus.cmd_in    = cmd;
        bus.add_in    = a;
        chk("req_ready", bus.req_ready, exp_rdy);
        if (exp_push) sb.push_back('{cmd, a, exp_err});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.cmd_in    = 2'b00;
    endtask

    // returns at a negedge with mem_req high
    task automatic wait_mreq();
        int n = 0;
        @(negedge clk);
        while (bus.mem_req !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("mem_req_wait", bus.mem_req, 1);
    endtask

    task automatic serve(input int dly, input logic we, input logic [25:0] a);
        wait_mreq();
        chk("mem_we", bus.mem_we, we);
        chk("mem_addr", bus.mem_addr, a);
        repeat (dly) @(posedge clk);
        #1 bus.mem_ack = 1'b1;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drain", sb.size(), 0);
        sync();
    endtask

    initial begin
        int cnt;
        bus.req_valid = 1'b0;
        bus.cmd_in    = 2'b00;
        bus.add_in    = '0;
        bus.mem_ack   = 1'b0;

        // reset state
        #2 rst_n = 1'b0;
        #2;
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_addr", bus.resp_addr, 0);
        chk("rst_resp_cmd", bus.resp_cmd, 0);
        chk("rst_resp_err", bus.resp_err, 0);
        chk("rst_cnts", {read_cnt ^ write_cnt} | {16'h0, timeout_cnt | illegal_cnt}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        sync();

        // single READ, ack 3 cycles after mem_req
        send(2'b01, 26'h00ABCDE, 1, 1, 0);
        serve(3, 1'b0, 26'h00ABCDE);
        drain();
        chk("read_cnt_1", read_cnt, 1);

        // minimum latency: accept e0, mem_req after e1, ack e2, resp e2..e3
        send(2'b01, 26'h0000040, 1, 1, 0);
        @(negedge clk); chk("lat_mreq_e0", bus.mem_req, 0);
        @(negedge clk); chk("lat_mreq_e1", bus.mem_req, 1);
        bus.mem_ack = 1'b1;
        @(posedge clk); #1 bus.mem_ack = 1'b0;
        @(negedge clk); chk("lat_resp_e2", bus.resp_valid, 1);
        @(negedge clk); chk("lat_resp_e3", bus.resp_valid, 0);
        sync();

        // five back-to-back RFOs, no ack: fifth dropped; illegal counts while full
        for (int i = 0; i < 5; i++)
            send(2'b10, 26'h1000000 + 26'(i), (i < 4), (i < 4), 0);
        send(2'b11, 26'h2222222, 0, 0, 0);
        send(2'b00, 26'h3333333, 0, 0, 0);
        chk("write_cnt_4", write_cnt, 4);
        chk("illegal_full", illegal_cnt, 1);
        chk("read_cnt_2", read_cnt, 2);
        for (int i = 0; i < 4; i++)
            serve(1, 1'b1, 26'h1000000 + 26'(i));
        drain();
        chk("ready_after_drain", bus.req_ready, 1);

        // timeout: head held 64 cycles, then error; next entry then issued
        send(2'b01, 26'h0AAAAAA, 1, 1, 1);
        send(2'b10, 26'h0BBBBBB, 1, 1, 0);
        wait_mreq();
        cnt = 0;
        while (bus.mem_req === 1'b1 && bus.mem_addr === 26'h0AAAAAA && cnt < 300) begin
            cnt++;
            @(negedge clk);
        end
        chk("timeout_cycles", cnt, 64);
        sync();
        serve(1, 1'b1, 26'h0BBBBBB);
        drain();
        chk("timeout_cnt_1", timeout_cnt, 1);

        // ack on the timeout cycle wins
        send(2'b01, 26'h0CCCCCC, 1, 1, 0);
        wait_mreq();
        repeat (63) @(negedge clk);
        chk("coinc_mreq", bus.mem_req, 1);
        bus.mem_ack = 1'b1;
        @(posedge clk); #1 bus.mem_ack = 1'b0;
        drain();
        chk("timeout_cnt_coinc", timeout_cnt, 1);

        // stray ack in IDLE is ignored
        bus.mem_ack = 1'b1;
        sync();
        bus.mem_ack = 1'b0;
        repeat (5) sync();
        @(negedge clk);
        chk("idle_ack_mreq", bus.mem_req, 0);
        chk("idle_ack_resp", bus.resp_valid, 0);
        sync();

        // reset mid-REQ with three queued: everything dropped
        send(2'b01, 26'h0D00001, 1, 0, 0);
        send(2'b01, 26'h0D00002, 1, 0, 0);
        send(2'b10, 26'h0D00003, 1, 0, 0);
        wait_mreq();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_mem_req", bus.mem_req, 0);
        chk("midrst_ready", bus.req_ready, 1);
        chk("midrst_read_cnt", read_cnt, 0);
        chk("midrst_write_cnt", write_cnt, 0);
        chk("midrst_timeout_cnt", timeout_cnt, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        bus.mem_ack = 1'b1;
        sync();
        bus.mem_ack = 1'b0;
        repeat (10) sync();
        @(negedge clk);
        chk("postrst_mem_req", bus.mem_req, 0);
        sync();
        send(2'b01, 26'h0E0E0E0, 1, 1, 0);
        serve(0, 1'b0, 26'h0E0E0E0);
        drain();
        chk("postrst_read_cnt", read_cnt, 1);

        // illegal saturation: 65540 cycles of cmd 11
        bus.req_valid = 1'b1;
        bus.cmd_in    = 2'b11;
        repeat (65534) @(posedge clk);
        #1 chk("illegal_fffe", illegal_cnt, 16'hFFFE);
        repeat (6) @(posedge clk);
        #1 chk("illegal_sat", illegal_cnt, 16'hFFFF);
        chk("illegal_no_push", bus.req_ready, 1);
        bus.req_valid = 1'b0;
        bus.cmd_in    = 2'b00;
        repeat (3) sync();
        chk("illegal_no_mreq", bus.mem_req, 0);
        chk("sb_final", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
